// File: rtl/timer_bank_if.sv
// Control/status bundle for timer_bank: per-channel strobes and values in,
// counts and expiry status out.
interface timer_bank_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS-1:0]       periodic;
    logic [CHANNELS*WIDTH-1:0] load_value;
    logic [CHANNELS-1:0]       clear;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       last;
    logic [CHANNELS-1:0]       expire;
    logic [CHANNELS-1:0]       pending;
    logic                      irq;

    modport master (
        output enable, load, periodic, load_value, clear,
        input  count, last, expire, pending, irq
    );

    modport slave (
        input  enable, load, periodic, load_value, clear,
        output count, last, expire, pending, irq
    );
endinterface

// File: rtl/timer_bank.sv
// Bank of independent down-counters with one-shot / auto-reload modes,
// registered expiry pulses, sticky pending flags and a combined interrupt.
module timer_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    timer_bank_if.slave  bus
);

    logic [WIDTH-1:0]    r_count     [CHANNELS];
    logic [WIDTH-1:0]    r_reload    [CHANNELS];
    logic [WIDTH-1:0]    w_count_nxt [CHANNELS];
    logic [WIDTH-1:0]    w_reload_nxt[CHANNELS];
    logic [CHANNELS-1:0] r_expire;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] w_expire_nxt;
    logic [CHANNELS-1:0] w_pending_nxt;

    // Next-state: load beats counting and swallows any expiry due that edge.
    always_comb begin
        w_expire_nxt = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_count_nxt[i]  = r_count[i];
            w_reload_nxt[i] = r_reload[i];
            if (bus.load[i]) begin
                w_count_nxt[i]  = bus.load_value[i*WIDTH +: WIDTH];
                w_reload_nxt[i] = bus.load_value[i*WIDTH +: WIDTH];
            end else if (bus.enable[i] && (r_count[i] == WIDTH'(1))) begin
                w_count_nxt[i]  = bus.periodic[i] ? r_reload[i] : '0;
                w_expire_nxt[i] = 1'b1;
            end else if (bus.enable[i] && (r_count[i] > WIDTH'(1))) begin
                w_count_nxt[i]  = r_count[i] - WIDTH'(1);
            end
        end
        // A new expiry wins over a coincident clear.
        w_pending_nxt = w_expire_nxt | (r_pending & ~bus.clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_count[i]  <= '0;
                r_reload[i] <= '0;
            end
            r_expire  <= '0;
            r_pending <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_count[i]  <= w_count_nxt[i];
                r_reload[i] <= w_reload_nxt[i];
            end
            r_expire  <= w_expire_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign bus.count[g*WIDTH +: WIDTH] = r_count[g];
        assign bus.last[g] = bus.enable[g] & (r_count[g] <= WIDTH'(1));
    end

    assign bus.expire  = r_expire;
    assign bus.pending = r_pending;
    assign bus.irq     = |r_pending;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (WIDTH=8, CHANNELS=4): stimulus pushes the
// expected post-edge state, a monitor pops and compares after each edge.
module tb_timer_bank;

    localparam int unsigned W = 8;
    localparam int unsigned C = 4;

    typedef struct {
        int         id;
        int         ch;
        logic [7:0] cnt;
        logic       lst;
        logic       exp;
        logic [3:0] pend;
        logic       irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_id  = 0;

    timer_bank_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    timer_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endfunction

    function automatic void push_exp(input int ch, input logic [7:0] cnt,
                                     input logic lst, input logic exp,
                                     input logic [3:0] pend, input logic irq);
        exp_t e;
        e.id = step_id; e.ch = ch; e.cnt = cnt; e.lst = lst;
        e.exp = exp; e.pend = pend; e.irq = irq;
        step_id++;
        q.push_back(e);
    endfunction

    // Drive one channel's inputs at the falling edge and queue the
    // expected state after the following rising edge.
    task automatic cyc(input int ch, input logic en, input logic ld,
                       input logic per, input logic clr, input logic [7:0] lv,
                       input logic [7:0] ecnt, input logic elst, input logic eexp,
                       input logic [3:0] epend, input logic eirq);
        @(negedge clk);
        bus.enable[ch]              = en;
        bus.load[ch]                = ld;
        bus.periodic[ch]            = per;
        bus.clear[ch]               = clr;
        bus.load_value[ch*8 +: 8]   = lv;
        push_exp(ch, ecnt, elst, eexp, epend, eirq);
    endtask

    // Monitor: outputs settle just after each rising edge.
    always begin
        exp_t e;
        logic [7:0] act_cnt;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            act_cnt = bus.count[e.ch*8 +: 8];
            check($sformatf("step%0d ch%0d count", e.id, e.ch), 32'(act_cnt), 32'(e.cnt));
            check($sformatf("step%0d ch%0d last", e.id, e.ch), 32'(bus.last[e.ch]), 32'(e.lst));
            check($sformatf("step%0d ch%0d expire", e.id, e.ch), 32'(bus.expire[e.ch]), 32'(e.exp));
            check($sformatf("step%0d pending", e.id), 32'(bus.pending), 32'(e.pend));
            check($sformatf("step%0d irq", e.id), 32'(bus.irq), 32'(e.irq));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.enable     = '0;
        bus.load       = '0;
        bus.periodic   = '0;
        bus.clear      = '0;
        bus.load_value = '0;
        #12;
        check("reset count", bus.count, 32'h0);
        check("reset pending", 32'(bus.pending), 32'h0);
        check("reset irq", 32'(bus.irq), 32'h0);
        check("reset last", 32'(bus.last), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 one-shot from 3
        cyc(0, 0, 1, 0, 0, 8'd3, 8'd3, 0, 0, 4'h0, 0);
        cyc(0, 1, 0, 0, 0, 8'd3, 8'd2, 0, 0, 4'h0, 0);
        cyc(0, 1, 0, 0, 0, 8'd3, 8'd1, 1, 0, 4'h0, 0);
        cyc(0, 1, 0, 0, 0, 8'd3, 8'd0, 1, 1, 4'h1, 1);
        cyc(0, 1, 0, 0, 0, 8'd3, 8'd0, 1, 0, 4'h1, 1);
        cyc(0, 0, 0, 0, 1, 8'd3, 8'd0, 0, 0, 4'h0, 0);
        cyc(0, 0, 0, 0, 0, 8'd3, 8'd0, 0, 0, 4'h0, 0);

        // ch1 periodic reload 3, clear coincident with the third expiry
        cyc(1, 0, 1, 1, 0, 8'd3, 8'd3, 0, 0, 4'h0, 0);
        cyc(1, 1, 0, 1, 0, 8'd3, 8'd2, 0, 0, 4'h0, 0);
        cyc(1, 1, 0, 1, 0, 8'd3, 8'd1, 1, 0, 4'h0, 0);
        cyc(1, 1, 0, 1, 0, 8'd3, 8'd3, 0, 1, 4'h2, 1);
        cyc(1, 1, 0, 1, 0, 8'd3, 8'd2, 0, 0, 4'h2, 1);
        cyc(1, 1, 0, 1, 0, 8'd3, 8'd1, 1, 0, 4'h2, 1);
        cyc(1, 1, 0, 1, 0, 8'd3, 8'd3, 0, 1, 4'h2, 1);
        cyc(1, 1, 0, 1, 0, 8'd3, 8'd2, 0, 0, 4'h2, 1);
        cyc(1, 1, 0, 1, 0, 8'd3, 8'd1, 1, 0, 4'h2, 1);
        cyc(1, 1, 0, 1, 1, 8'd3, 8'd3, 0, 1, 4'h2, 1);
        cyc(1, 0, 0, 1, 1, 8'd3, 8'd3, 0, 0, 4'h0, 0);
        cyc(1, 0, 0, 1, 0, 8'd3, 8'd3, 0, 0, 4'h0, 0);

        // ch2 load held with enable, then pause and resume
        cyc(2, 1, 1, 0, 0, 8'd4, 8'd4, 0, 0, 4'h0, 0);
        cyc(2, 1, 1, 0, 0, 8'd4, 8'd4, 0, 0, 4'h0, 0);
        cyc(2, 1, 0, 0, 0, 8'd4, 8'd3, 0, 0, 4'h0, 0);
        cyc(2, 0, 0, 0, 0, 8'd4, 8'd3, 0, 0, 4'h0, 0);
        cyc(2, 0, 0, 0, 0, 8'd4, 8'd3, 0, 0, 4'h0, 0);
        cyc(2, 1, 0, 0, 0, 8'd4, 8'd2, 0, 0, 4'h0, 0);
        cyc(2, 0, 0, 0, 0, 8'd4, 8'd2, 0, 0, 4'h0, 0);

        // ch3 load at count 1 suppresses expiry; periodic reload of 0 stays 0
        cyc(3, 0, 1, 1, 0, 8'd2, 8'd2, 0, 0, 4'h0, 0);
        cyc(3, 1, 0, 1, 0, 8'd2, 8'd1, 1, 0, 4'h0, 0);
        cyc(3, 1, 1, 1, 0, 8'd5, 8'd5, 0, 0, 4'h0, 0);
        cyc(3, 1, 1, 1, 0, 8'd0, 8'd0, 1, 0, 4'h0, 0);
        cyc(3, 1, 0, 1, 0, 8'd0, 8'd0, 1, 0, 4'h0, 0);
        cyc(3, 1, 0, 1, 0, 8'd0, 8'd0, 1, 0, 4'h0, 0);
        cyc(3, 0, 0, 1, 0, 8'd0, 8'd0, 0, 0, 4'h0, 0);

        // ch0 periodic reload 1: expires every enabled cycle
        cyc(0, 0, 1, 1, 0, 8'd1, 8'd1, 0, 0, 4'h0, 0);
        cyc(0, 1, 0, 1, 0, 8'd1, 8'd1, 1, 1, 4'h1, 1);
        cyc(0, 1, 0, 1, 0, 8'd1, 8'd1, 1, 1, 4'h1, 1);
        cyc(0, 1, 0, 1, 0, 8'd1, 8'd1, 1, 1, 4'h1, 1);
        cyc(0, 0, 0, 1, 0, 8'd1, 8'd1, 0, 0, 4'h1, 1);

        // All channels counting, then asynchronous reset between edges
        @(negedge clk);
        bus.enable     = 4'hF;
        bus.load       = 4'hF;
        bus.periodic   = 4'h0;
        bus.clear      = 4'h0;
        bus.load_value = {8'd40, 8'd30, 8'd20, 8'd10};
        push_exp(1, 8'd20, 0, 0, 4'h1, 1);
        @(negedge clk);
        bus.load = 4'h0;
        push_exp(1, 8'd19, 0, 0, 4'h1, 1);
        @(negedge clk);
        push_exp(2, 8'd28, 0, 0, 4'h1, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset count", bus.count, 32'h0);
        check("async reset pending", 32'(bus.pending), 32'h0);
        check("async reset irq", 32'(bus.irq), 32'h0);
        check("async reset expire", 32'(bus.expire), 32'h0);
        check("async reset last", 32'(bus.last), 32'hF);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) rst_n = 1'b1;
            push_exp(c, 8'd0, 1, 0, 4'h0, 0);
        end

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected items left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
